// File: rtl/mem_lsu.sv
// mem_lsu: MEM-stage load/store unit running a req/ack data-memory transaction with alignment, extension and timeout
module mem_lsu #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        ld,
  input  logic        st,
  input  logic [1:0]  size,
  input  logic        uext,
  input  logic [31:0] addr,
  input  logic [31:0] sdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] dmem_out,
  output logic        done,
  output logic        stall,
  output logic        misalign,
  output logic        bus_err
);
  localparam int CW = $clog2(TIMEOUT);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [1:0] sz_q, a_q;
  logic uext_q, issue, aligned;
  logic [3:0] be_c;
  logic [31:0] wdata_c, ld_val;
  logic [7:0] byte_v;
  logic [15:0] half_v;
  assign issue = ld | st;
  assign aligned = size[1] ? (addr[1:0] == 2'b00) : size[0] ? !addr[0] : 1'b1;
  assign stall = (state == BUSY) | (issue & aligned);
  assign byte_v = mem_rdata[{a_q, 3'b000} +: 8];
  assign half_v = a_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
  // store lane placement and load alignment/extension
  always_comb begin
    be_c = size[1] ? 4'b1111 : size[0] ? (addr[1] ? 4'b1100 : 4'b0011) : 4'b0001 << addr[1:0];
    wdata_c = size[1] ? sdata : size[0] ? {2{sdata[15:0]}} : {4{sdata[7:0]}};
    ld_val = sz_q[1] ? mem_rdata
           : sz_q[0] ? {{16{!uext_q & half_v[15]}}, half_v}
           : {{24{!uext_q & byte_v[7]}}, byte_v};
  end
  // IDLE/BUSY transaction FSM with registered bus and status outputs
  always_ff @(posedge clk) begin
    if (!clrn) begin
      state <= IDLE;
      cnt <= '0;
      mem_req <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_be <= '0;
      mem_wdata <= '0;
      sz_q <= '0;
      a_q <= '0;
      uext_q <= 1'b0;
      dmem_out <= '0;
      done <= 1'b0;
      misalign <= 1'b0;
      bus_err <= 1'b0;
    end else begin
      done <= 1'b0;
      misalign <= 1'b0;
      bus_err <= 1'b0;
      if (state == IDLE) begin
        if (issue && aligned) begin
          state <= BUSY;
          cnt <= '0;
          mem_req <= 1'b1;
          mem_we <= !ld;
          mem_addr <= {addr[31:2], 2'b00};
          mem_be <= be_c;
          mem_wdata <= wdata_c;
          sz_q <= size;
          a_q <= addr[1:0];
          uext_q <= uext;
        end else if (issue) begin
          misalign <= 1'b1;
        end
      end else if (mem_ack) begin
        state <= IDLE;
        mem_req <= 1'b0;
        done <= 1'b1;
        if (!mem_we) dmem_out <= ld_val;
      end else if (cnt == CW'(TIMEOUT - 1)) begin
        state <= IDLE;
        mem_req <= 1'b0;
        bus_err <= 1'b1;
        dmem_out <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: random and directed checks of mem_lsu against a transaction-level reference model
module tb_mem_lsu;
  localparam int TIMEOUT = 16;
  logic clk = 0, clrn = 0, ld = 0, st = 0, uext = 0, mem_ack = 0;
  logic [1:0] size = 0;
  logic [31:0] addr = 0, sdata = 0, mem_rdata = 0;
  logic mem_req, mem_we, done, stall, misalign, bus_err;
  logic [31:0] mem_addr, mem_wdata, dmem_out;
  logic [3:0] mem_be;
  int checks = 0, errors = 0;
  logic last_stall;
  bit m_busy;
  int m_left, m_nb, m_a;
  bit m_uext;
  logic e_req, e_we, e_done, e_mis, e_err;
  logic [31:0] e_addr, e_wdata, e_dout;
  logic [3:0] e_be;

  mem_lsu #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .clrn(clrn), .ld(ld), .st(st), .size(size), .uext(uext),
    .addr(addr), .sdata(sdata), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .dmem_out(dmem_out),
    .done(done), .stall(stall), .misalign(misalign), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int nbytes(input logic [1:0] s);
    return s == 2'd0 ? 1 : s == 2'd1 ? 2 : 4;
  endfunction

  function automatic logic [31:0] extract(input logic [31:0] w);
    longint v;
    v = longint'(w) >> (8 * m_a);
    if (m_nb == 1) begin
      v = v % 256;
      if (!m_uext && v >= 128) v = v - 256;
    end else if (m_nb == 2) begin
      v = v % 65536;
      if (!m_uext && v >= 32768) v = v - 65536;
    end
    return v[31:0];
  endfunction

  task automatic clear_model();
    m_busy = 0;
    {e_req, e_we, e_done, e_mis, e_err} = '0;
    e_addr = 0; e_wdata = 0; e_dout = 0; e_be = 0;
  endtask

  task automatic cyc();
    int nb;
    bit ok;
    nb = nbytes(size);
    ok = (addr % nb) == 0;
    #1;
    chk("stall", stall, m_busy || ((ld || st) && ok));
    last_stall = stall;
    e_done = 0; e_mis = 0; e_err = 0;
    if (!clrn) clear_model();
    else if (!m_busy) begin
      if ((ld || st) && ok) begin
        m_busy = 1; m_left = TIMEOUT;
        m_nb = nb; m_a = addr % 4; m_uext = uext;
        e_req = 1; e_we = !ld;
        e_addr = addr - (addr % 4);
        e_be = 4'(((1 << nb) - 1) << (addr % 4));
        e_wdata = nb == 1 ? sdata[7:0] * 32'h01010101 : nb == 2 ? sdata[15:0] * 32'h00010001 : sdata;
      end else if (ld || st) e_mis = 1;
    end else if (mem_ack) begin
      m_busy = 0; e_req = 0; e_done = 1;
      if (!e_we) e_dout = extract(mem_rdata);
    end else begin
      m_left--;
      if (m_left == 0) begin
        m_busy = 0; e_req = 0; e_err = 1; e_dout = 0;
      end
    end
    @(posedge clk);
    @(negedge clk);
    chk("mem_req", mem_req, e_req);
    chk("done", done, e_done);
    chk("misalign", misalign, e_mis);
    chk("bus_err", bus_err, e_err);
    chk("dmem_out", dmem_out, e_dout);
    if (e_req) begin
      chk("mem_we", mem_we, e_we);
      chk("mem_addr", mem_addr, e_addr);
      chk("mem_be", mem_be, e_be);
      chk("mem_wdata", mem_wdata, e_wdata);
    end
  endtask

  task automatic quiet();
    clrn = 1; ld = 0; st = 0; mem_ack = 0;
  endtask

  task automatic issue(input bit l, input bit s, input logic [1:0] sz, input bit u, input logic [31:0] a, input logic [31:0] d);
    quiet();
    ld = l; st = s; size = sz; uext = u; addr = a; sdata = d;
    cyc();
    quiet();
  endtask

  task automatic ack(input logic [31:0] r);
    quiet();
    mem_ack = 1; mem_rdata = r;
    cyc();
    quiet();
  endtask

  initial begin
    int sc, n;
    clear_model();
    @(negedge clk);
    clrn = 0;
    cyc();
    quiet();
    chk("rst_req", mem_req, 0);
    chk("rst_dout", dmem_out, 0);
    chk("rst_pulses", {done, misalign, bus_err, mem_we}, 0);
    chk("rst_bus", {mem_be, mem_addr | mem_wdata}, 0);
    // load word, ack on 3rd BUSY cycle
    issue(1, 0, 2'b10, 0, 32'h100, 0);
    sc = int'(last_stall);
    chk("t1_addr", mem_addr, 32'h100);
    chk("t1_be", mem_be, 4'b1111);
    cyc(); sc += int'(last_stall);
    cyc(); sc += int'(last_stall);
    ack(32'hDEADBEEF); sc += int'(last_stall);
    chk("t1_stall_cycles", sc, 4);
    chk("t1_done", done, 1);
    chk("t1_dout", dmem_out, 32'hDEADBEEF);
    // byte load sign/zero extension
    issue(1, 0, 2'b00, 0, 32'h103, 0);
    ack(32'h80FF0000);
    chk("t2_sext", dmem_out, 32'hFFFFFF80);
    issue(1, 0, 2'b00, 1, 32'h103, 0);
    ack(32'h80FF0000);
    chk("t2_zext", dmem_out, 32'h00000080);
    // half store lanes
    issue(0, 1, 2'b01, 0, 32'h202, 32'h1234ABCD);
    chk("t3_addr", mem_addr, 32'h200);
    chk("t3_be", mem_be, 4'b1100);
    chk("t3_wdata", mem_wdata, 32'hABCDABCD);
    chk("t3_we", mem_we, 1);
    ack(0);
    chk("t3_hold", dmem_out, 32'h00000080);
    // misaligned word load
    issue(1, 0, 2'b10, 0, 32'h101, 0);
    chk("t4_stall", last_stall, 0);
    chk("t4_mis", misalign, 1);
    chk("t4_req", mem_req, 0);
    chk("t4_dout", dmem_out, 32'h00000080);
    // timeout
    issue(1, 0, 2'b10, 0, 32'h300, 0);
    n = 0;
    for (int k = 0; k < 20; k++) begin
      if (mem_req) n++;
      if (bus_err) break;
      cyc();
    end
    chk("t5_busy_cycles", n, 16);
    chk("t5_err", bus_err, 1);
    chk("t5_req", mem_req, 0);
    chk("t5_dout", dmem_out, 0);
    #1 chk("t5_stall", stall, 0);
    // reset mid-BUSY, then back-to-back loads
    issue(1, 0, 2'b10, 0, 32'h400, 0);
    cyc();
    clrn = 0; cyc(); quiet();
    ack(32'h55555555);
    chk("t6_done", done, 0);
    chk("t6_req", mem_req, 0);
    chk("t6_dout", dmem_out, 0);
    issue(1, 0, 2'b10, 0, 32'h40, 0);
    ack(32'h11111111);
    chk("t6_done1", done, 1);
    issue(1, 0, 2'b10, 0, 32'h44, 0);
    chk("t6_b2b_stall", last_stall, 1);
    chk("t6_b2b_req", mem_req, 1);
    chk("t6_b2b_addr", mem_addr, 32'h44);
    ack(32'h22222222);
    chk("t6_dout2", dmem_out, 32'h22222222);
    // randomized traffic, with stretches of no acks to exercise timeouts
    for (int i = 0; i < 4000; i++) begin
      clrn = $urandom_range(0, 299) != 0;
      ld = $urandom_range(0, 3) == 0;
      st = $urandom_range(0, 3) == 0;
      size = 2'($urandom);
      uext = 1'($urandom);
      addr = $urandom;
      sdata = $urandom;
      mem_rdata = $urandom;
      mem_ack = ((i / 500) % 4 == 3) ? 1'b0 : $urandom_range(0, 3) == 0;
      cyc();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
